fetch_unit: RTL and testbench

Instruction fetch stage of the single-cycle/multicycle RISC-V core, directly upstream of the opcode decoder. Holds the PC and fetches 32-bit words from instruction memory over a req/ack handshake. It presents each word, with its PC, to decode over a valid/ready handshake and drives the 7-bit opcode field consumed by the control decoder. Taken branches and jumps are accepted as a redirect from the execute/branch-resolution logic; wrong-path fetches are discarded.

---
 rtl/fetch_unit.sv | 91 +++++++++
 tb/tb_fetch_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with imem req/ack, decode valid/ready and redirect kill
module fetch_unit #(
  parameter int TAM_ADDR = 32,
  parameter int TAM_DATA = 32,
  parameter int TAM_INS = 7,
  parameter logic [TAM_ADDR-1:0] RESET_PC = '0
) (
  input  logic                CLK,
  input  logic                RST_N,
  output logic                IMEM_REQ,
  output logic [TAM_ADDR-1:0] IMEM_ADDR,
  input  logic                IMEM_ACK,
  input  logic [TAM_DATA-1:0] IMEM_RDATA,
  input  logic                REDIRECT,
  input  logic [TAM_ADDR-1:0] REDIRECT_PC,
  output logic                INS_VALID,
  input  logic                INS_READY,
  output logic [TAM_DATA-1:0] INS_WORD,
  output logic [TAM_ADDR-1:0] INS_PC,
  output logic [TAM_INS-1:0]  OPCODE
);
  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;
  state_t state_q, state_d;
  logic [TAM_ADDR-1:0] pc_q, pc_d, ins_pc_q, ins_pc_d, pend_q, pend_d;
  logic [TAM_DATA-1:0] word_q, word_d;
  logic kill_q, kill_d;
  logic [TAM_ADDR-1:0] target;
  assign target = REDIRECT_PC & ~TAM_ADDR'(3);
  // state and datapath registers, reset dominates
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      ins_pc_q <= '0;
      pend_q   <= '0;
      word_q   <= TAM_DATA'(32'h0000_0013);
      kill_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ins_pc_q <= ins_pc_d;
      pend_q   <= pend_d;
      word_q   <= word_d;
      kill_q   <= kill_d;
    end
  end
  // next state: a killed or redirected ack re-requests, a clean ack holds for decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = REQ;
      REQ:     state_d = (IMEM_ACK && !kill_q && !REDIRECT) ? HOLD : REQ;
      HOLD:    state_d = (REDIRECT || INS_READY) ? REQ : HOLD;
      default: state_d = IDLE;
    endcase
  end
  // datapath: PC steering, pending redirect target and captured instruction
  always_comb begin
    pc_d     = pc_q;
    ins_pc_d = ins_pc_q;
    pend_d   = pend_q;
    word_d   = word_q;
    kill_d   = kill_q;
    case (state_q)
      IDLE, HOLD: pc_d = REDIRECT ? target : pc_q;
      REQ: begin
        if (IMEM_ACK && (kill_q || REDIRECT)) begin
          pc_d   = REDIRECT ? target : pend_q;
          kill_d = 1'b0;
        end else if (IMEM_ACK) begin
          word_d   = IMEM_RDATA;
          ins_pc_d = pc_q;
          pc_d     = pc_q + TAM_ADDR'(4);
        end else if (REDIRECT) begin
          kill_d = 1'b1;
          pend_d = target;
        end
      end
      default: pc_d = pc_q;
    endcase
  end
  // Moore outputs decoded from the state register only
  always_comb begin
    IMEM_REQ  = state_q == REQ;
    INS_VALID = state_q == HOLD;
  end
  assign IMEM_ADDR = pc_q;
  assign INS_WORD  = word_q;
  assign INS_PC    = ins_pc_q;
  assign OPCODE    = word_q[TAM_INS-1:0];
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit with a wait-state memory model
module tb_fetch_unit;
  logic        CLK, RST_N, IMEM_REQ, IMEM_ACK, REDIRECT, INS_VALID, INS_READY;
  logic [31:0] IMEM_ADDR, IMEM_RDATA, REDIRECT_PC, INS_WORD, INS_PC;
  logic [6:0]  OPCODE;
  int n_tests = 0, n_fail = 0, cyc = 0;
  logic [31:0] exp_pc[$], exp_w[$];
  int xfer_cyc[$];
  logic [31:0] dly_addr = 32'hFFFF_FFFF;
  int dly_n = 0;

  fetch_unit dut (
    .CLK(CLK), .RST_N(RST_N), .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR),
    .IMEM_ACK(IMEM_ACK), .IMEM_RDATA(IMEM_RDATA), .REDIRECT(REDIRECT),
    .REDIRECT_PC(REDIRECT_PC), .INS_VALID(INS_VALID), .INS_READY(INS_READY),
    .INS_WORD(INS_WORD), .INS_PC(INS_PC), .OPCODE(OPCODE)
  );

  initial begin
    CLK = 0;
    forever #5 CLK = ~CLK;
  end

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  function automatic logic [31:0] memword(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0050_0093;
      32'h0000_0004: return 32'h00A0_0113;
      32'h0000_0008: return 32'h0020_81B3;
      32'h0000_000C: return 32'h0031_0233;
      32'h0000_0010: return 32'hDEAD_BE13;
      32'h0000_0100: return 32'h0000_006F;
      32'h0000_0200: return 32'h0010_0073;
      32'hFFFF_FFFC: return 32'h0000_0513;
      default:       return {a[23:0], 8'h33};
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc);
    exp_pc.push_back(pc);
    exp_w.push_back(memword(pc));
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic wait_hold(input logic [31:0] a);
    bit found = 0;
    for (int i = 0; i < 50; i++) begin
      if (INS_VALID === 1'b1 && INS_PC === a) begin
        INS_READY = 0;
        found = 1;
        break;
      end
      tick();
    end
    if (!found) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_hold timeout: no valid at pc %h, INS_PC=%h", a, INS_PC);
      INS_READY = 0;
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " imem_req"}, {31'b0, IMEM_REQ}, 32'd0);
    chk({tag, " ins_valid"}, {31'b0, INS_VALID}, 32'd0);
    chk({tag, " imem_addr"}, IMEM_ADDR, 32'h0);
    chk({tag, " ins_word"}, INS_WORD, 32'h0000_0013);
    chk({tag, " opcode"}, {25'b0, OPCODE}, 32'h13);
    chk({tag, " ins_pc"}, INS_PC, 32'h0);
  endtask

  // memory model: acks after dly_n wait cycles at dly_addr, zero-wait elsewhere
  initial begin
    int cnt = 0;
    IMEM_ACK = 0;
    IMEM_RDATA = 0;
    forever begin
      @(negedge CLK);
      if (IMEM_REQ === 1'b1) begin
        if (cnt >= ((IMEM_ADDR == dly_addr) ? dly_n : 0)) begin
          IMEM_ACK = 1;
          IMEM_RDATA = memword(IMEM_ADDR);
          cnt = 0;
        end else begin
          IMEM_ACK = 0;
          cnt++;
        end
      end else begin
        IMEM_ACK = 0;
        cnt = 0;
      end
    end
  end

  // monitor: every transfer pops one expected instruction
  initial forever begin
    @(negedge CLK);
    #1;
    if (INS_VALID === 1'b1 && INS_READY === 1'b1 && REDIRECT === 1'b0) begin
      xfer_cyc.push_back(cyc);
      if (exp_pc.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected transfer: pc %h word %h, expected none", INS_PC, INS_WORD);
      end else begin
        logic [31:0] p, w;
        p = exp_pc.pop_front();
        w = exp_w.pop_front();
        chk("xfer pc", INS_PC, p);
        chk("xfer word", INS_WORD, w);
        chk("xfer opcode", {25'b0, OPCODE}, {25'b0, w[6:0]});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", n_tests);
    $fatal(1);
  end

  initial begin
    int n;
    RST_N = 0; INS_READY = 0; REDIRECT = 0; REDIRECT_PC = 0;
    tick(); tick();
    chk_reset("reset");
    // streaming, zero-wait, decode always ready
    push(32'h0); push(32'h4); push(32'h8); push(32'hC);
    RST_N = 1; INS_READY = 1;
    wait_hold(32'h10);
    if (xfer_cyc.size() >= 4) chk("4 xfers span", 32'(xfer_cyc[3] - xfer_cyc[0]), 32'd6);
    else chk("4 xfers count", 32'(xfer_cyc.size()), 32'd4);
    // 3 wait cycles at 0x8 reached via redirect from HOLD
    dly_addr = 32'h8; dly_n = 3;
    REDIRECT = 1; REDIRECT_PC = 32'h8;
    tick();
    REDIRECT = 0;
    n = 0;
    while (IMEM_REQ === 1'b1 && IMEM_ADDR === 32'h8 && n < 10) begin
      n++;
      tick();
    end
    chk("wait req cycles", 32'(n), 32'd4);
    chk("valid after ack", {31'b0, INS_VALID}, 32'd1);
    chk("pc after ack", INS_PC, 32'h8);
    dly_n = 0;
    // decode stalls five cycles
    push(32'h8);
    for (int i = 0; i < 5; i++) begin
      chk("stall hold", {IMEM_REQ, INS_VALID, INS_PC[29:0]}, {1'b0, 1'b1, 30'h8});
      chk("stall word", INS_WORD, memword(32'h8));
      tick();
    end
    INS_READY = 1;
    tick();
    chk("addr after stall", IMEM_ADDR, 32'hC);
    chk("req after stall", {31'b0, IMEM_REQ}, 32'd1);
    push(32'hC);
    wait_hold(32'h10);
    // redirect in HOLD with ready high is not a transfer
    REDIRECT = 1; REDIRECT_PC = 32'h100; INS_READY = 1;
    tick();
    REDIRECT = 0;
    chk("redir hold valid", {31'b0, INS_VALID}, 32'd0);
    chk("redir hold addr", IMEM_ADDR, 32'h100);
    chk("redir hold req", {31'b0, IMEM_REQ}, 32'd1);
    push(32'h100);
    wait_hold(32'h104);
    // redirect during a wait-state request kills that fetch
    dly_addr = 32'h10; dly_n = 3;
    REDIRECT = 1; REDIRECT_PC = 32'h10;
    tick();
    REDIRECT = 0;
    chk("kill req addr n1", IMEM_ADDR, 32'h10);
    tick();
    REDIRECT = 1; REDIRECT_PC = 32'h203;
    tick();
    REDIRECT = 0;
    chk("kill req addr n3", {IMEM_REQ, INS_VALID, IMEM_ADDR[29:0]}, {1'b1, 1'b0, 30'h10});
    tick();
    chk("kill req addr ack", {IMEM_REQ, INS_VALID, IMEM_ADDR[29:0]}, {1'b1, 1'b0, 30'h10});
    tick();
    chk("kill new addr", IMEM_ADDR, 32'h200);
    chk("kill no valid", {IMEM_REQ, INS_VALID}, {30'b0, 2'b10});
    dly_n = 0;
    push(32'h200);
    INS_READY = 1;
    wait_hold(32'h204);
    // PC wrap from the top of the address space
    REDIRECT = 1; REDIRECT_PC = 32'hFFFF_FFFC;
    tick();
    REDIRECT = 0;
    chk("wrap first addr", IMEM_ADDR, 32'hFFFF_FFFC);
    push(32'hFFFF_FFFC);
    INS_READY = 1;
    wait_hold(32'h0);
    // reset while a request is waiting
    dly_addr = 32'h4; dly_n = 5;
    push(32'h0);
    INS_READY = 1;
    tick();
    INS_READY = 0;
    chk("pre-reset req", {IMEM_REQ, IMEM_ADDR[30:0]}, {1'b1, 31'h4});
    RST_N = 0;
    tick();
    chk_reset("mid-req reset");
    RST_N = 1;
    dly_n = 0;
    repeat (6) tick();
    chk("scoreboard drained", 32'(exp_pc.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
